// File: rtl/uart_trx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_trx : UART transceiver core, one TX shifter and one RX sampler with  |
// |            runtime baud divisor, parity and stop-bit configuration.       |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module uart_trx #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DIV_WIDTH-1:0]  div_i,
  input  logic                  par_en_i,
  input  logic                  par_odd_i,
  input  logic                  stop2_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  output logic                  rx_valid_o,
  input  logic                  rx_ready_i,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_perr_o,
  output logic                  rx_ferr_o,
  output logic                  rx_oerr_o,
  input  logic                  err_clr_i,
  input  logic [2:0]            irq_en_i,
  input  logic                  uart_rx_i,
  output logic                  uart_tx_o,
  output logic                  irq_o
);

  localparam logic [3:0]           c_LAST_BIT = 4'(DATA_WIDTH - 1);
  localparam logic [DIV_WIDTH-1:0] c_CNT_ONE  = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // ---------------------------------------------------------------- TX ----
  state_t                r_tx_state;
  state_t                w_tx_state_nxt;
  logic [DIV_WIDTH-1:0]  r_tx_cnt;
  logic [DIV_WIDTH-1:0]  r_tx_div;
  logic [DATA_WIDTH-1:0] r_tx_shift;
  logic [3:0]            r_tx_bitcnt;
  logic                  r_tx_par_en;
  logic                  r_tx_par_bit;
  logic                  r_tx_stop_left;
  logic                  r_tx_line;
  logic                  w_tx_tick;
  logic                  w_tx_ready;

  assign w_tx_tick  = (r_tx_cnt == '0);
  assign w_tx_ready = (r_tx_state == S_IDLE);

  always_comb begin
    w_tx_state_nxt = r_tx_state;
    case (r_tx_state)
      S_IDLE:   if (tx_valid_i) w_tx_state_nxt = S_START;
      S_START:  if (w_tx_tick) w_tx_state_nxt = S_DATA;
      S_DATA:   if (w_tx_tick && (r_tx_bitcnt == c_LAST_BIT))
                  w_tx_state_nxt = r_tx_par_en ? S_PARITY : S_STOP;
      S_PARITY: if (w_tx_tick) w_tx_state_nxt = S_STOP;
      S_STOP:   if (w_tx_tick && !r_tx_stop_left) w_tx_state_nxt = S_IDLE;
      default:  w_tx_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_tx_state <= S_IDLE;
    else       r_tx_state <= w_tx_state_nxt;
  end

  // Frame configuration is captured at accept so the frame in flight is immune to input changes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tx_cnt       <= '0;
      r_tx_div       <= '0;
      r_tx_shift     <= '0;
      r_tx_bitcnt    <= '0;
      r_tx_par_en    <= 1'b0;
      r_tx_par_bit   <= 1'b0;
      r_tx_stop_left <= 1'b0;
      r_tx_line      <= 1'b1;
    end else if (r_tx_state == S_IDLE) begin
      if (tx_valid_i) begin
        r_tx_div       <= div_i;
        r_tx_cnt       <= div_i;
        r_tx_shift     <= tx_data_i;
        r_tx_par_en    <= par_en_i;
        r_tx_par_bit   <= (^tx_data_i) ^ par_odd_i;
        r_tx_stop_left <= stop2_i;
        r_tx_bitcnt    <= '0;
        r_tx_line      <= 1'b0;
      end
    end else if (!w_tx_tick) begin
      r_tx_cnt <= r_tx_cnt - c_CNT_ONE;
    end else begin
      r_tx_cnt <= r_tx_div;
      if (r_tx_state == S_START) begin
        r_tx_line   <= r_tx_shift[0];
        r_tx_shift  <= r_tx_shift >> 1;
        r_tx_bitcnt <= '0;
      end else if (r_tx_state == S_DATA) begin
        if (r_tx_bitcnt == c_LAST_BIT) begin
          r_tx_line <= r_tx_par_en ? r_tx_par_bit : 1'b1;
        end else begin
          r_tx_line   <= r_tx_shift[0];
          r_tx_shift  <= r_tx_shift >> 1;
          r_tx_bitcnt <= r_tx_bitcnt + 4'd1;
        end
      end else if (r_tx_state == S_PARITY) begin
        r_tx_line <= 1'b1;
      end else begin
        r_tx_stop_left <= 1'b0;
      end
    end
  end

  assign uart_tx_o  = r_tx_line;
  assign tx_ready_o = w_tx_ready;

  // ---------------------------------------------------------------- RX ----
  logic                  r_rx_sync1;
  logic                  r_rx_sync2;
  state_t                r_rx_state;
  state_t                w_rx_state_nxt;
  logic [DIV_WIDTH-1:0]  r_rx_cnt;
  logic [DIV_WIDTH-1:0]  r_rx_div;
  logic [DATA_WIDTH-1:0] r_rx_shift;
  logic [3:0]            r_rx_bitcnt;
  logic                  r_rx_par_en;
  logic                  r_rx_par_odd;
  logic                  r_rx_par_bit;
  logic                  w_rx_tick;
  logic                  w_rx_done;
  logic                  w_rx_perr;
  logic                  w_rx_ferr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rx_sync1 <= 1'b1;
      r_rx_sync2 <= 1'b1;
    end else begin
      r_rx_sync1 <= uart_rx_i;
      r_rx_sync2 <= r_rx_sync1;
    end
  end

  assign w_rx_tick = (r_rx_cnt == '0);
  assign w_rx_done = (r_rx_state == S_STOP) && w_rx_tick;
  assign w_rx_perr = r_rx_par_en & (r_rx_par_bit != ((^r_rx_shift) ^ r_rx_par_odd));
  assign w_rx_ferr = ~r_rx_sync2;

  always_comb begin
    w_rx_state_nxt = r_rx_state;
    case (r_rx_state)
      S_IDLE:   if (!r_rx_sync2) w_rx_state_nxt = S_START;
      S_START:  if (w_rx_tick) w_rx_state_nxt = r_rx_sync2 ? S_IDLE : S_DATA;
      S_DATA:   if (w_rx_tick && (r_rx_bitcnt == c_LAST_BIT))
                  w_rx_state_nxt = r_rx_par_en ? S_PARITY : S_STOP;
      S_PARITY: if (w_rx_tick) w_rx_state_nxt = S_STOP;
      S_STOP:   if (w_rx_tick) w_rx_state_nxt = S_IDLE;
      default:  w_rx_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_rx_state <= S_IDLE;
    else       r_rx_state <= w_rx_state_nxt;
  end

  // Half-period initial count centres every later sample in its bit cell.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rx_cnt     <= '0;
      r_rx_div     <= '0;
      r_rx_shift   <= '0;
      r_rx_bitcnt  <= '0;
      r_rx_par_en  <= 1'b0;
      r_rx_par_odd <= 1'b0;
      r_rx_par_bit <= 1'b0;
    end else if (r_rx_state == S_IDLE) begin
      if (!r_rx_sync2) begin
        r_rx_div     <= div_i;
        r_rx_cnt     <= div_i >> 1;
        r_rx_par_en  <= par_en_i;
        r_rx_par_odd <= par_odd_i;
        r_rx_bitcnt  <= '0;
      end
    end else if (!w_rx_tick) begin
      r_rx_cnt <= r_rx_cnt - c_CNT_ONE;
    end else begin
      r_rx_cnt <= r_rx_div;
      if (r_rx_state == S_DATA) begin
        r_rx_shift  <= {r_rx_sync2, r_rx_shift[DATA_WIDTH-1:1]};
        r_rx_bitcnt <= r_rx_bitcnt + 4'd1;
      end else if (r_rx_state == S_PARITY) begin
        r_rx_par_bit <= r_rx_sync2;
      end
    end
  end

  // ------------------------------------------------- output register / irq
  logic                  r_rx_valid;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic                  r_rx_perr;
  logic                  r_rx_ferr;
  logic                  r_rx_oerr;
  logic                  r_irq;
  logic                  w_rx_load;

  assign w_rx_load = w_rx_done && (!r_rx_valid || rx_ready_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rx_valid <= 1'b0;
      r_rx_data  <= '0;
      r_rx_perr  <= 1'b0;
      r_rx_ferr  <= 1'b0;
    end else if (w_rx_load) begin
      r_rx_valid <= 1'b1;
      r_rx_data  <= r_rx_shift;
      r_rx_perr  <= w_rx_perr;
      r_rx_ferr  <= w_rx_ferr;
    end else if (r_rx_valid && rx_ready_i) begin
      r_rx_valid <= 1'b0;
      r_rx_perr  <= 1'b0;
      r_rx_ferr  <= 1'b0;
    end
  end

  // A dropped byte outranks a simultaneous clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                   r_rx_oerr <= 1'b0;
    else if (w_rx_done && r_rx_valid && !rx_ready_i) r_rx_oerr <= 1'b1;
    else if (err_clr_i)                          r_rx_oerr <= 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_irq <= 1'b0;
    else       r_irq <= (r_rx_valid & irq_en_i[0]) | (w_tx_ready & irq_en_i[1]) |
                        ((r_rx_perr | r_rx_ferr | r_rx_oerr) & irq_en_i[2]);
  end

  assign rx_valid_o = r_rx_valid;
  assign rx_data_o  = r_rx_data;
  assign rx_perr_o  = r_rx_perr;
  assign rx_ferr_o  = r_rx_ferr;
  assign rx_oerr_o  = r_rx_oerr;
  assign irq_o      = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_uart_trx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_trx : directed self-checking bench for uart_trx.                  |
// | Revision    : 1.0                                                         |
// +--------------------------------------------------------------------------+
module tb_uart_trx;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] div;
  logic        par_en, par_odd, stop2;
  logic        tx_valid, tx_ready;
  logic [7:0]  tx_data;
  logic        rx_valid, rx_ready;
  logic [7:0]  rx_data;
  logic        rx_perr, rx_ferr, rx_oerr, err_clr;
  logic [2:0]  irq_en;
  logic        uart_rx, uart_tx, irq;
  logic        loop, rx_drv;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;
  assign uart_rx = loop ? uart_tx : rx_drv;

  uart_trx #(.DATA_WIDTH(8), .DIV_WIDTH(16)) dut (
    .clk_i(clk), .rst_i(rst), .div_i(div), .par_en_i(par_en), .par_odd_i(par_odd),
    .stop2_i(stop2), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready), .tx_data_i(tx_data),
    .rx_valid_o(rx_valid), .rx_ready_i(rx_ready), .rx_data_o(rx_data),
    .rx_perr_o(rx_perr), .rx_ferr_o(rx_ferr), .rx_oerr_o(rx_oerr), .err_clr_i(err_clr),
    .irq_en_i(irq_en), .uart_rx_i(uart_rx), .uart_tx_o(uart_tx), .irq_o(irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (rx_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, rx_valid}, 32'd1);
  endtask

  // Start bit, data LSB first and optional parity; the caller drives the stop bit.
  task automatic send_head(input logic [7:0] data, input bit pe, input bit pb, input int d);
    rx_drv = 1'b0;
    repeat (d + 1) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = data[i];
      repeat (d + 1) @(negedge clk);
    end
    if (pe) begin
      rx_drv = pb;
      repeat (d + 1) @(negedge clk);
    end
  endtask

  task automatic send_stop(input int d);
    rx_drv = 1'b1;
    repeat (d + 1) @(negedge clk);
  endtask

  task automatic consume;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  initial begin
    logic [9:0] fr;
    int         low_cnt;
    int         n;

    rst = 1'b1; div = 16'd9; par_en = 0; par_odd = 0; stop2 = 0;
    tx_valid = 0; tx_data = 8'h00; rx_ready = 0; err_clr = 0; irq_en = 3'b000;
    loop = 0; rx_drv = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx", {31'd0, uart_tx}, 32'd1);
    check("rst_ready", {31'd0, tx_ready}, 32'd1);
    check("rst_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_data", {24'd0, rx_data}, 32'd0);
    check("rst_errs", {29'd0, rx_perr, rx_ferr, rx_oerr}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: 0xA5, 8N1, div 9; data input changed after accept
    tx_data = 8'hA5; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0; tx_data = 8'h00;
    fr = {1'b1, 8'hA5, 1'b0};
    low_cnt = 0;
    for (int k = 0; k < 100; k++) begin
      check($sformatf("t1_tx_k%0d", k), {31'd0, uart_tx}, {31'd0, fr[k/10]});
      if (tx_ready === 1'b0) low_cnt++;
      @(negedge clk);
    end
    check("t1_ready_back", {31'd0, tx_ready}, 32'd1);
    check("t1_low_cycles", low_cnt, 32'd100);

    // 2: loopback, odd parity, 0x3C -> parity bit 1
    par_en = 1; par_odd = 1; irq_en = 3'b001; loop = 1;
    tx_data = 8'h3C; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (95) @(negedge clk);
    check("t2_tx_parity", {31'd0, uart_tx}, 32'd1);
    wait_valid("t2_valid", 60);
    check("t2_data", {24'd0, rx_data}, 32'h3C);
    check("t2_perr", {31'd0, rx_perr}, 32'd0);
    check("t2_ferr", {31'd0, rx_ferr}, 32'd0);
    @(negedge clk);
    check("t2_irq", {31'd0, irq}, 32'd1);
    consume();
    check("t2_consumed", {31'd0, rx_valid}, 32'd0);
    n = 0;
    while (tx_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t2_tx_done", {31'd0, tx_ready}, 32'd1);
    loop = 0;

    // 3: even parity, 0x3C with flipped parity bit (correct would be 0)
    par_en = 1; par_odd = 0; irq_en = 3'b100;
    @(negedge clk);
    send_head(8'h3C, 1'b1, 1'b1, 9);
    send_stop(9);
    wait_valid("t3_valid", 20);
    check("t3_data", {24'd0, rx_data}, 32'h3C);
    check("t3_perr", {31'd0, rx_perr}, 32'd1);
    check("t3_ferr", {31'd0, rx_ferr}, 32'd0);
    @(negedge clk);
    check("t3_irq", {31'd0, irq}, 32'd1);
    consume();
    check("t3_valid_clr", {31'd0, rx_valid}, 32'd0);
    check("t3_perr_clr", {31'd0, rx_perr}, 32'd0);
    check("t3_data_kept", {24'd0, rx_data}, 32'h3C);
    @(negedge clk);
    check("t3_irq_clr", {31'd0, irq}, 32'd0);

    // 4: 0x55 with low stop bit, then a good frame ~5 cycles later
    par_en = 0; irq_en = 3'b000;
    send_head(8'h55, 1'b0, 1'b0, 9);
    rx_drv = 1'b0;
    wait_valid("t4_valid", 30);
    rx_drv = 1'b1;
    check("t4_data", {24'd0, rx_data}, 32'h55);
    check("t4_ferr", {31'd0, rx_ferr}, 32'd1);
    check("t4_perr", {31'd0, rx_perr}, 32'd0);
    consume();
    repeat (3) @(negedge clk);
    send_head(8'h96, 1'b0, 1'b0, 9);
    send_stop(9);
    wait_valid("t4b_valid", 20);
    check("t4b_data", {24'd0, rx_data}, 32'h96);
    check("t4b_errs", {30'd0, rx_perr, rx_ferr}, 32'd0);
    consume();

    // 5: overrun
    send_head(8'h11, 1'b0, 1'b0, 9);
    send_stop(9);
    wait_valid("t5_valid", 20);
    check("t5_data1", {24'd0, rx_data}, 32'h11);
    send_head(8'h22, 1'b0, 1'b0, 9);
    send_stop(9);
    check("t5_data_held", {24'd0, rx_data}, 32'h11);
    check("t5_oerr", {31'd0, rx_oerr}, 32'd1);
    check("t5_still_valid", {31'd0, rx_valid}, 32'd1);
    consume();
    check("t5_valid_clr", {31'd0, rx_valid}, 32'd0);
    check("t5_oerr_sticky", {31'd0, rx_oerr}, 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("t5_oerr_clr", {31'd0, rx_oerr}, 32'd0);

    // 6: glitch rejection at div 15, then async reset mid-TX
    div = 16'd15;
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    check("t6_no_valid", {31'd0, rx_valid}, 32'd0);
    check("t6_no_flags", {29'd0, rx_perr, rx_ferr, rx_oerr}, 32'd0);

    div = 16'd9; tx_data = 8'h00; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (25) @(negedge clk);
    check("t6_mid_tx", {31'd0, uart_tx}, 32'd0);
    check("t6_mid_ready", {31'd0, tx_ready}, 32'd0);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_tx", {31'd0, uart_tx}, 32'd1);
    check("t6_rst_ready", {31'd0, tx_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
